shift_issue_stage: RTL and testbench
====================================

// Module: shift_issue_stage
//
// PURPOSE
// - Pipelined front end for the 16-bit barrelShifter. Accepts shift requests {data, cnt, op} over a
//   valid/ready handshake and buffers them in a small FIFO. Issues the FIFO head through one
//   barrelShifter instance and registers the result on a valid/ready output port.
// - Sits between execute-stage operand select and writeback.
// - Decouples producer stalls from consumer stalls without dropping or duplicating requests.
//
// PARAMETERS
// - N      16  data width; must match the barrelShifter width
// - CT     4   shift count width (shift amounts 0..2^CT-1)
// - DEPTH  2   input FIFO entries; power of two, >= 2
//
// PORTS
// - clk        in   1         clock; all state updates on the rising edge
// - rst_n      in   1         reset; asynchronous assert, active-low
// - in_valid   in   1         request present
// - in_ready   out  1         FIFO can accept a request; equals !full
// - in_data    in   N         operand
// - in_cnt     in   CT        shift amount
// - in_op      in   2         00 rotl, 01 shl (zero fill), 10 sra (sign fill), 11 srl (zero fill)
// - out_valid  out  1         out_data holds a result
// - out_ready  in   1         consumer accepts the result
// - out_data   out  N         registered shift result
// - occupancy  out  log2(DEPTH)+1  entries in the FIFO; excludes the output register
// - out_zero   out  1         exists only when SHIFT_ZERO_FLAG_EN is defined; high when out_data == 0
//
// BEHAVIOUR
// - Reset (rst_n low, async): FIFO empty, rd_ptr = 0, wr_ptr = 0, occupancy = 0.
//   - Outputs: out_valid = 0, out_data = 0, out_zero = 0.
//   - in_ready = 1 one cycle after rst_n deasserts. While rst_n is low, in_ready = 0.
// - Accept: on a clk edge with in_valid && in_ready, write {in_data, in_cnt, in_op} at wr_ptr.
//   wr_ptr increments mod DEPTH.
// - Output slot is free when !out_valid || out_ready.
// - Issue: on each edge where the slot is free and a request is available, out_data <= shift(request)
//   and out_valid <= 1.
//   - The request is the FIFO head when occupancy > 0; otherwise it is the input being accepted
//     this edge (bypass).
//   - With an empty FIFO, the bypassed request is not written to the FIFO.
// - Slot free but nothing available: out_valid <= 0 and out_data holds its value.
// - Latency: 1 cycle from accept to out_valid when idle. Throughput: 1 result per cycle when
//   out_ready is held high.
// - Ordering: results appear strictly in accept order. Every request is issued exactly once.
// - FIFO full with a pop on the same edge: in_ready stays 0 that cycle. in_ready never depends
//   combinationally on out_ready.
// - FIFO empty, slot blocked (out_valid && !out_ready): an accepted request goes into the FIFO.
// - Simultaneous push and pop: occupancy is unchanged, and both pointers advance mod DEPTH.
// - Stall: while out_valid && !out_ready, out_data and out_zero stay stable.
// - Shift rules: the amount is taken mod 2^CT.
//   - cnt = 0 passes data through unchanged for every op.
//   - The sign for sra is bit N-1 of the unshifted operand.
// - Reset during operation: all in-flight requests are discarded. No output transaction
//   completes on the reset edge.
//
// CONFIGURATION
// - SHIFT_ZERO_FLAG_EN defined: out_zero is registered alongside out_data and equals (result == 0).
//   It follows the same load and hold rules as out_data.
// - SHIFT_ZERO_FLAG_EN undefined: there is no out_zero port and no extra logic. All other
//   behaviour is identical.
//
// TESTING
// - Reset, then one rotl request {0x8001, cnt 1, op 00} with out_ready=1
//   -> out_valid the next cycle, out_data = 0x0003.
// - sra {0x8000, 4, 10} -> 0xF800. srl {0x8000, 15, 11} -> 0x0001.
//   shl {0x00FF, 8, 01} -> 0xFF00. Any op with cnt 0 on 0xA5C3 -> 0xA5C3.
// - Hold out_ready=0 and push 3 requests -> third push gives in_ready=0 with occupancy=2.
//   Raise out_ready -> 3 results in order, one per cycle.
// - Drive in_valid=1 and out_ready=1 every cycle with 16 distinct requests -> 16 back-to-back
//   results and occupancy stays 0.
// - Pull rst_n low with 2 queued requests and one pending output -> out_valid=0 and occupancy=0
//   immediately. No stale result appears after release.
// - With SHIFT_ZERO_FLAG_EN: shl {0x8000, 1, 01} -> out_zero=1. Next request rotl {0x8000, 1, 00}
//   -> out_data 0x0001, out_zero=0.

Source files
------------

// File: rtl/shift_issue_stage.sv
// Shift issue stage: buffers {data, cnt, op} requests in a small FIFO and issues them through a
// barrel shifter into a registered valid/ready output. Define SHIFT_ZERO_FLAG_EN to add out_zero.

module barrelShifter #(
    parameter int N  = 16,
    parameter int CT = 4
) (
    input  logic [N-1:0]  data,
    input  logic [CT-1:0] cnt,
    input  logic [1:0]    op,
    output logic [N-1:0]  result
);

    logic [N-1:0]        r;
    logic [2*N-1:0]      dbl;
    logic signed [N-1:0] sr;

    // Log-depth shifter: stage k shifts by 2^k when cnt[k] is set. Arithmetic shifts keep the
    // original sign bit in the MSB, so every sra stage fills with the operand's sign.
    always_comb begin
        r   = data;
        dbl = '0;
        sr  = '0;
        for (int k = 0; k < CT; k++) begin
            if (cnt[k]) begin
                case (op)
                    2'b00: begin
                        dbl = {r, r} << (1 << k);
                        r   = dbl[2*N-1:N];
                    end
                    2'b01: r = r << (1 << k);
                    2'b10: begin
                        sr = r;
                        r  = sr >>> (1 << k);
                    end
                    default: r = r >> (1 << k);
                endcase
            end
        end
        result = r;
    end

endmodule

module shift_issue_stage #(
    parameter int N     = 16,
    parameter int CT    = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_data,
    input  logic [CT-1:0]            in_cnt,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    output logic                     out_zero
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    typedef struct packed {
        logic [N-1:0]  data;
        logic [CT-1:0] cnt;
        logic [1:0]    op;
    } req_t;

    req_t          mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [OW-1:0] count_p0;
    logic          rdy_p0;

    logic          fifo_empty;
    logic          fifo_full;
    logic          accept;
    logic          slot_free;
    logic          issue;
    logic          push;
    logic          pop;
    req_t          in_req;
    req_t          issue_req;
    logic [N-1:0]  shift_res;

    assign fifo_empty = (count_p0 == '0);
    assign fifo_full  = (count_p0 == OW'(DEPTH));
    // in_ready depends only on registered state, never on out_ready.
    assign in_ready   = rdy_p0 && !fifo_full;
    assign occupancy  = count_p0;

    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign issue     = slot_free && (!fifo_empty || accept);
    assign pop       = issue && !fifo_empty;
    // An accepted request skips the FIFO only when it is issued directly from an empty FIFO.
    assign push      = accept && !(issue && fifo_empty);

    assign in_req    = '{data: in_data, cnt: in_cnt, op: in_op};
    assign issue_req = fifo_empty ? in_req : mem[rd_ptr];

    barrelShifter #(
        .N  (N),
        .CT (CT)
    ) u_shift (
        .data   (issue_req.data),
        .cnt    (issue_req.cnt),
        .op     (issue_req.op),
        .result (shift_res)
    );

    // ---- stage p0: FIFO storage and control ----
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_p0   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_p0 <= '0;
        end else begin
            rdy_p0 <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_p0 <= count_p0 + 1'b1;
            end else if (pop && !push) begin
                count_p0 <= count_p0 - 1'b1;
            end
        end
    end

    // ---- stage p1: registered result ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_data  <= shift_res;
        end else if (slot_free) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SHIFT_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero <= 1'b0;
        end else if (issue) begin
            out_zero <= (shift_res == '0);
        end
    end
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed self-checking bench for shift_issue_stage (N=16, CT=4, DEPTH=2).
// Exercises the out_zero flag as well when SHIFT_ZERO_FLAG_EN is defined.

module tb_shift_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  occupancy;
`ifdef SHIFT_ZERO_FLAG_EN
    logic        out_zero;
`endif

    int errors = 0;
    int checks = 0;

    shift_issue_stage #(
        .N     (16),
        .CT    (4),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef SHIFT_ZERO_FLAG_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial reference: one single-bit shift per count step.
    function automatic logic [15:0] model(input logic [15:0] d, input int c, input logic [1:0] op);
        logic [15:0] r;
        r = d;
        for (int s = 0; s < c; s++) begin
            case (op)
                2'b00:   r = {r[14:0], r[15]};
                2'b01:   r = {r[14:0], 1'b0};
                2'b10:   r = {d[15], r[15:1]};
                default: r = {1'b0, r[15:1]};
            endcase
        end
        return r;
    endfunction

    task automatic drive(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op);
        in_valid = 1'b1;
        in_data  = d;
        in_cnt   = c;
        in_op    = op;
    endtask

    task automatic single(input string tag, input logic [15:0] d, input logic [3:0] c,
                          input logic [1:0] op, input logic [15:0] exp);
        drive(d, c, op);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
        check(tag, out_data, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cnt    = '0;
        in_op     = '0;
        out_ready = 1'b0;

        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_occupancy", occupancy, 0);
`ifdef SHIFT_ZERO_FLAG_EN
        check("rst_out_zero", out_zero, 0);
`endif
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // Single requests with out_ready high: result one cycle after accept.
        single("rotl_8001_1", 16'h8001, 4'd1, 2'b00, 16'h0003);
        single("sra_8000_4", 16'h8000, 4'd4, 2'b10, 16'hF800);
        single("srl_8000_15", 16'h8000, 4'd15, 2'b11, 16'h0001);
        single("shl_00ff_8", 16'h00FF, 4'd8, 2'b01, 16'hFF00);
        single("rotl_1234_4", 16'h1234, 4'd4, 2'b00, 16'h2341);
        single("sra_7f00_3", 16'h7F00, 4'd3, 2'b10, 16'h0FE0);
        single("rotl_a5c3_0", 16'hA5C3, 4'd0, 2'b00, 16'hA5C3);
        single("shl_a5c3_0", 16'hA5C3, 4'd0, 2'b01, 16'hA5C3);
        single("sra_a5c3_0", 16'hA5C3, 4'd0, 2'b10, 16'hA5C3);
        single("srl_a5c3_0", 16'hA5C3, 4'd0, 2'b11, 16'hA5C3);
        check("single_occupancy", occupancy, 0);
        tick();
        check("idle_out_valid", out_valid, 0);
        check("idle_out_data_hold", out_data, 16'hA5C3);

        // Backpressure: first request bypasses to the output, next two fill the FIFO.
        out_ready = 1'b0;
        drive(16'h0001, 4'd1, 2'b01);
        tick();
        check("bp_a_valid", out_valid, 1);
        check("bp_a_data", out_data, 16'h0002);
        check("bp_a_occ", occupancy, 0);
        drive(16'h0001, 4'd2, 2'b01);
        tick();
        check("bp_b_occ", occupancy, 1);
        check("bp_b_in_ready", in_ready, 1);
        drive(16'h0001, 4'd3, 2'b01);
        tick();
        check("bp_full_in_ready", in_ready, 0);
        check("bp_full_occ", occupancy, 2);
        drive(16'hFFFF, 4'd1, 2'b11);
        tick();
        check("bp_reject_occ", occupancy, 2);
        check("bp_stall_valid", out_valid, 1);
        check("bp_stall_data", out_data, 16'h0002);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_b_valid", out_valid, 1);
        check("bp_b_data", out_data, 16'h0004);
        check("bp_pop1_occ", occupancy, 1);
        check("bp_pop1_in_ready", in_ready, 1);
        tick();
        check("bp_c_valid", out_valid, 1);
        check("bp_c_data", out_data, 16'h0008);
        check("bp_pop2_occ", occupancy, 0);
        tick();
        check("bp_drain_valid", out_valid, 0);

        // Streaming: 16 back-to-back requests with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] d;
            logic [3:0]  c;
            logic [1:0]  o;
            d = 16'hA5C3 ^ (16'(i) * 16'h1357);
            c = 4'(i);
            o = 2'(i);
            drive(d, c, o);
            tick();
            check($sformatf("stream%0d_valid", i), out_valid, 1);
            check($sformatf("stream%0d_data", i), out_data, model(d, i, o));
            check($sformatf("stream%0d_occ", i), occupancy, 0);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_valid", out_valid, 0);

        // Reset with two queued requests and one pending output.
        out_ready = 1'b0;
        drive(16'h0003, 4'd1, 2'b01);
        tick();
        drive(16'h0003, 4'd2, 2'b01);
        tick();
        drive(16'h0003, 4'd3, 2'b01);
        tick();
        in_valid = 1'b0;
        check("pre_rst_occ", occupancy, 2);
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_in_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst%0d_valid", i), out_valid, 0);
            check($sformatf("post_rst%0d_occ", i), occupancy, 0);
        end
        single("post_rst_srl", 16'h00F0, 4'd4, 2'b11, 16'h000F);

`ifdef SHIFT_ZERO_FLAG_EN
        single("zf_shl_8000_1", 16'h8000, 4'd1, 2'b01, 16'h0000);
        check("zf_set", out_zero, 1);
        single("zf_rotl_8000_1", 16'h8000, 4'd1, 2'b00, 16'h0001);
        check("zf_clear", out_zero, 0);
        out_ready = 1'b0;
        drive(16'h4000, 4'd2, 2'b01);
        tick();
        in_valid = 1'b0;
        check("zf_load_zero", out_zero, 1);
        tick();
        check("zf_stall_hold", out_zero, 1);
        out_ready = 1'b1;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
